// File: rtl/synthesijer_fdiv64_arbiter.sv
// synthesijer_fdiv64_arbiter
// Shares one pipelined, fixed-latency synthesijer_fdiv64 among NUM_REQ requesters.
// Round-robin grant, at most one issue per cycle, in-order tag FIFO routes results back.
// Optional statistics counters are built only when FDIV_ARB_STATS_EN is defined.
module synthesijer_fdiv64_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [64*NUM_REQ-1:0]   req_a,
    input  logic [64*NUM_REQ-1:0]   req_b,
    output logic [63:0]             div_a,
    output logic [63:0]             div_b,
    output logic                    div_nd,
    input  logic [63:0]             div_result,
    input  logic                    div_valid,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [63:0]             rsp_result,
    output logic                    err_orphan,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_stall
);

    localparam int TAG_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_INFLIGHT);
    localparam logic [TAG_W-1:0] TAG_LAST = TAG_W'(NUM_REQ - 1);

    logic [63:0]        op_a [NUM_REQ];
    logic [63:0]        op_b [NUM_REQ];

    logic [TAG_W-1:0]   rr_q, rr_d;
    logic [TAG_W-1:0]   tag_mem_q [MAX_INFLIGHT];
    logic [TAG_W-1:0]   tag_mem_d [MAX_INFLIGHT];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_nd_q, div_nd_d;
    logic [63:0]        div_a_q, div_a_d;
    logic [63:0]        div_b_q, div_b_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [63:0]        rsp_result_q, rsp_result_d;
    logic               err_orphan_q, err_orphan_d;

    logic               grant_found;
    logic [TAG_W-1:0]   grant_idx;
    logic               fifo_full;
    logic               accept;
    logic               pop;
    logic               orphan;

    // Split the packed operand buses into per-requester words.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_a[gi] = req_a[64*gi +: 64];
        assign op_b[gi] = req_b[64*gi +: 64];
    end

    // Round-robin search: first asserted request at or after the pointer, wrapping.
    always_comb begin
        logic [TAG_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_q} + (TAG_W+1)'(k);
            if (cand >= (TAG_W+1)'(NUM_REQ)) begin
                cand = cand - (TAG_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[cand[TAG_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[TAG_W-1:0];
            end
        end
    end

    // Grant is withheld when the tag FIFO is full (pre-pop count) or while in reset.
    always_comb begin
        fifo_full = (cnt_q == CNT_FULL);
        req_ready = '0;
        if (grant_found && !fifo_full && !reset) begin
            req_ready[grant_idx] = 1'b1;
        end
        accept = |req_ready;
        pop    = div_valid && (cnt_q != '0);
        orphan = div_valid && (cnt_q == '0);
    end

    // Next-state for issue path, tag FIFO, response path and orphan flag.
    always_comb begin
        rr_d         = rr_q;
        tag_mem_d    = tag_mem_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        div_nd_d     = accept;
        div_a_d      = div_a_q;
        div_b_d      = div_b_q;
        rsp_valid_d  = '0;
        rsp_result_d = rsp_result_q;
        err_orphan_d = err_orphan_q | orphan;

        if (accept) begin
            div_a_d           = op_a[grant_idx];
            div_b_d           = op_b[grant_idx];
            tag_mem_d[wr_q]   = grant_idx;
            wr_d              = wr_q + PTR_W'(1);
            rr_d              = (grant_idx == TAG_LAST) ? '0 : grant_idx + TAG_W'(1);
        end

        if (pop) begin
            rsp_valid_d[tag_mem_q[rd_q]] = 1'b1;
            rsp_result_d                 = div_result;
            rd_d                         = rd_q + PTR_W'(1);
        end

        if (accept && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!accept && pop) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // State registers; reset empties the FIFO and returns the pointer to requester 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q         <= '0;
            tag_mem_q    <= '{default: '0};
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            div_nd_q     <= 1'b0;
            div_a_q      <= '0;
            div_b_q      <= '0;
            rsp_valid_q  <= '0;
            rsp_result_q <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_q         <= rr_d;
            tag_mem_q    <= tag_mem_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            div_nd_q     <= div_nd_d;
            div_a_q      <= div_a_d;
            div_b_q      <= div_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign div_nd     = div_nd_q;
    assign div_a      = div_a_q;
    assign div_b      = div_b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign err_orphan = err_orphan_q;

`ifdef FDIV_ARB_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Issue and full-stall counters, both free-running and wrapping.
    always_comb begin
        stat_issued_d = stat_issued_q + (accept ? 32'd1 : 32'd0);
        stat_stall_d  = stat_stall_q + (((|req_valid) && fifo_full) ? 32'd1 : 32'd0);
    end

    // Counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif

endmodule

// File: tb/tb_synthesijer_fdiv64_arbiter.sv
// tb_synthesijer_fdiv64_arbiter
// Drives the arbiter against a fixed-latency divider model (L=8) with MAX_INFLIGHT=4.
// A behavioural model predicts grants, issue outputs and tagged responses each cycle.
module tb_synthesijer_fdiv64_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int MAX_INFLIGHT = 4;
    localparam int LAT          = 8;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [64*NUM_REQ-1:0]  req_a;
    logic [64*NUM_REQ-1:0]  req_b;
    logic [63:0]            div_a;
    logic [63:0]            div_b;
    logic                   div_nd;
    logic [63:0]            div_result;
    logic                   div_valid;
    logic [NUM_REQ-1:0]     rsp_valid;
    logic [63:0]            rsp_result;
    logic                   err_orphan;
    logic [31:0]            stat_issued;
    logic [31:0]            stat_stall;

    logic [63:0]            a_op [NUM_REQ];
    logic [63:0]            b_op [NUM_REQ];

    int total = 0;
    int bad   = 0;

    synthesijer_fdiv64_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .div_a       (div_a),
        .div_b       (div_b),
        .div_nd      (div_nd),
        .div_result  (div_result),
        .div_valid   (div_valid),
        .rsp_valid   (rsp_valid),
        .rsp_result  (rsp_result),
        .err_orphan  (err_orphan),
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
    );

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
        assign req_a[64*gi +: 64] = a_op[gi];
        assign req_b[64*gi +: 64] = b_op[gi];
    end

    // Divider model: fixed latency, unaffected by the arbiter reset.
    logic [LAT-1:0] pipe_v = '0;
    logic [63:0]    pipe_r [LAT];
    always @(posedge clk) begin
        pipe_v[0] <= div_nd;
        pipe_r[0] <= $realtobits($bitstoreal(div_a) / $bitstoreal(div_b));
        for (int k = 1; k < LAT; k++) begin
            pipe_v[k] <= pipe_v[k-1];
            pipe_r[k] <= pipe_r[k-1];
        end
    end
    assign div_valid  = pipe_v[LAT-1];
    assign div_result = pipe_r[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    function automatic int first_set(input logic [NUM_REQ-1:0] v);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Reference model and scoreboard, evaluated mid-cycle.
    typedef struct {
        logic [1:0]  tag;
        logic [63:0] res;
    } sb_t;
    sb_t sb[$];

    logic [1:0]         m_rr;
    int                 m_cnt;
    logic [NUM_REQ-1:0] m_rsp_v;
    logic [63:0]        m_rsp_r;
    logic               m_nd;
    logic [63:0]        m_a;
    logic [63:0]        m_b;
    logic               m_orphan;
    logic [31:0]        m_issued;
    logic [31:0]        m_stall;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        logic [1:0]         g;
        bit                 found;
        bit                 push;
        bit                 pop;
        int                 idx;
        sb_t                e;
        if (reset) begin
            sb.delete();
            m_rr     = '0;
            m_cnt    = 0;
            m_rsp_v  = '0;
            m_rsp_r  = '0;
            m_nd     = 1'b0;
            m_a      = '0;
            m_b      = '0;
            m_orphan = 1'b0;
            m_issued = '0;
            m_stall  = '0;
        end else begin
            check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_v));
            check("rsp_result", rsp_result, m_rsp_r);
            check("div_nd", 64'(div_nd), 64'(m_nd));
            check("div_a", div_a, m_a);
            check("div_b", div_b, m_b);
            check("err_orphan", 64'(err_orphan), 64'(m_orphan));
`ifdef FDIV_ARB_STATS_EN
            check("stat_issued", 64'(stat_issued), 64'(m_issued));
            check("stat_stall", 64'(stat_stall), 64'(m_stall));
`else
            check("stat_issued_tied", 64'(stat_issued), 64'd0);
            check("stat_stall_tied", 64'(stat_stall), 64'd0);
`endif
            exp_ready = '0;
            found     = 1'b0;
            g         = '0;
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(m_rr) + k) % NUM_REQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g     = 2'(idx);
                end
            end
            push = found && (m_cnt < MAX_INFLIGHT);
            if (push) exp_ready[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_ready));

            if ((|req_valid) && m_cnt == MAX_INFLIGHT) m_stall++;
            pop  = div_valid && (m_cnt > 0);
            m_nd = push;
            if (push) begin
                m_a = a_op[g];
                m_b = b_op[g];
                e.tag = g;
                e.res = $realtobits($bitstoreal(a_op[g]) / $bitstoreal(b_op[g]));
                sb.push_back(e);
                m_rr = 2'((int'(g) + 1) % NUM_REQ);
                m_issued++;
            end
            m_rsp_v = '0;
            if (pop) begin
                e = sb.pop_front();
                m_rsp_v[e.tag] = 1'b1;
                m_rsp_r = e.res;
            end else if (div_valid) begin
                m_orphan = 1'b1;
            end
            m_cnt = m_cnt + (push ? 1 : 0) - (pop ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        int                 acc;
        int                 gi;
        int                 pulses;
        int                 issued;
        int                 acc_cyc [5];
        int                 gseq [8];
        logic [NUM_REQ-1:0] g;
        logic [NUM_REQ-1:0] rsp_seen;
        bit                 got;

        reset     = 1'b1;
        req_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_op[i] = $realtobits(1.0);
            b_op[i] = $realtobits(1.0);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        $display("[TB] reset state");
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_div_nd", 64'(div_nd), 64'd0);
        check("rst_div_a", div_a, 64'd0);
        check("rst_div_b", div_b, 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_result", rsp_result, 64'd0);
        check("rst_err_orphan", 64'(err_orphan), 64'd0);

        $display("[TB] single op");
        tick();
        a_op[1]   = $realtobits(6.0);
        b_op[1]   = $realtobits(2.0);
        req_valid = 4'b0010;
        @(negedge clk);
        check("single_ready", 64'(req_ready), 64'(4'b0010));
        tick();
        req_valid = '0;
        @(negedge clk);
        check("single_nd", 64'(div_nd), 64'd1);
        check("single_div_a", div_a, $realtobits(6.0));
        check("single_div_b", div_b, $realtobits(2.0));
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("single_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
        check("single_rsp_result", rsp_result, $realtobits(3.0));

        $display("[TB] round robin");
        pulse_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            a_op[i] = $realtobits(real'(10 * (i + 1)));
            b_op[i] = $realtobits(4.0);
        end
        for (int k = 0; k < 8; k++) gseq[k] = -1;
        acc = 0;
        req_valid = 4'b1111;
        for (int c = 0; c < 60 && acc < 8; c++) begin
            @(negedge clk);
            g = req_valid & req_ready;
            tick();
            if (g != '0) begin
                gi = first_set(g);
                gseq[acc] = gi;
                acc++;
                a_op[gi] = $realtobits(real'(100 * acc + gi));
                if (acc == 8) req_valid = '0;
            end
        end
        req_valid = '0;
        check("rr_accepts", 64'(acc), 64'd8);
        for (int k = 0; k < 8; k++) begin
            check("rr_grant_order", 64'(gseq[k]), 64'(k % NUM_REQ));
        end
        repeat (25) tick();
        check("rr_drained", 64'(sb.size()), 64'd0);

        $display("[TB] full fifo");
        a_op[0] = $realtobits(9.0);
        b_op[0] = $realtobits(8.0);
        for (int k = 0; k < 5; k++) acc_cyc[k] = -1;
        acc = 0;
        req_valid = 4'b0001;
        for (int c = 0; c < 40 && acc < 5; c++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) begin
                acc_cyc[acc] = c;
                acc++;
            end
            tick();
            if (acc == 5) req_valid = '0;
        end
        req_valid = '0;
        check("full_acc0", 64'(acc_cyc[0]), 64'd0);
        check("full_acc1", 64'(acc_cyc[1]), 64'd1);
        check("full_acc2", 64'(acc_cyc[2]), 64'd2);
        check("full_acc3", 64'(acc_cyc[3]), 64'd3);
        check("full_first_after_pop", 64'(acc_cyc[4]), 64'd10);
        repeat (25) tick();
        check("full_drained", 64'(sb.size()), 64'd0);

        $display("[TB] continuous push/pop at count==MAX-1");
        req_valid = 4'b0001;
        repeat (40) tick();
        req_valid = '0;
        repeat (25) tick();
        check("steady_drained", 64'(sb.size()), 64'd0);

        $display("[TB] reset with three ops in flight");
        a_op[2] = $realtobits(9.0);
        b_op[2] = $realtobits(3.0);
        acc = 0;
        req_valid = 4'b0100;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            @(negedge clk);
            if ((req_valid & req_ready) != '0) acc++;
            tick();
            if (acc == 3) req_valid = '0;
        end
        req_valid = '0;
        check("orph_issued", 64'(acc), 64'd3);
        tick();
        tick();
        pulse_reset();
        pulses   = 0;
        rsp_seen = '0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (div_valid === 1'b1) pulses++;
            rsp_seen = rsp_seen | rsp_valid;
            tick();
        end
        check("orph_late_pulses", 64'(pulses), 64'd3);
        check("orph_no_rsp", 64'(rsp_seen), 64'd0);
        check("orph_flag", 64'(err_orphan), 64'd1);

        a_op[3]   = $realtobits(7.0);
        b_op[3]   = $realtobits(2.0);
        req_valid = 4'b1000;
        @(negedge clk);
        check("post_rst_ready", 64'(req_ready), 64'(4'b1000));
        tick();
        req_valid = '0;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                got = 1'b1;
                check("post_rst_rsp_valid", 64'(rsp_valid), 64'(4'b1000));
                check("post_rst_rsp_result", rsp_result, $realtobits(3.5));
            end
            tick();
        end
        check("post_rst_rsp_seen", 64'(got), 64'd1);
        check("post_rst_orphan_sticky", 64'(err_orphan), 64'd1);

        $display("[TB] random traffic, 100 accepts");
        pulse_reset();
        issued = 0;
        for (int c = 0; c < 3000 && issued < 100; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    a_op[i] = $realtobits(real'($urandom_range(1, 100000)) / 8.0);
                    b_op[i] = $realtobits(real'($urandom_range(1, 1000)) / 4.0);
                end
            end
            @(negedge clk);
            g = req_valid & req_ready;
            if (g != '0) issued++;
            tick();
            req_valid = req_valid & ~g;
            if (issued == 100) req_valid = '0;
        end
        req_valid = '0;
        repeat (30) tick();
        @(negedge clk);
        check("rand_issued", 64'(issued), 64'd100);
`ifdef FDIV_ARB_STATS_EN
        check("rand_stat_issued", 64'(stat_issued), 64'd100);
`else
        check("rand_stat_issued_zero", 64'(stat_issued), 64'd0);
        check("rand_stat_stall_zero", 64'(stat_stall), 64'd0);
`endif
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        check("final_no_orphan", 64'(err_orphan), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
